// File: rtl/control_unit.sv
// control_unit: instruction sequencer holding PC and IR, fetching 16-bit words
// from a synchronous instruction ROM and driving the datapath control bus from
// a Moore FSM. Control outputs are registered from the next state/IR so they
// are glitch-free and clear asynchronously with the rest of the state.
module control_unit #(
    parameter int PC_W = 7
) (
    input  logic            Clock,
    input  logic            n_rst,
    output logic [PC_W-1:0] I_Addr,
    input  logic [15:0]     I_Data,
    output logic [7:0]      D_Addr,
    output logic            D_Wr,
    output logic            RF_s,
    output logic [3:0]      RF_W_Addr,
    output logic            RF_W_en,
    output logic [3:0]      RF_Ra_Addr,
    output logic [3:0]      RF_Rb_Addr,
    output logic [2:0]      ALU_s0,
    output logic            Halted,
    output logic [PC_W-1:0] PC_out,
    output logic [15:0]     IR_out,
    output logic [3:0]      State_out
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    state_t            state;
    state_t            state_next;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_next;
    logic [15:0]       ir;
    logic [15:0]       ir_next;

    logic [7:0]        d_addr_next;
    logic              d_wr_next;
    logic              rf_s_next;
    logic [3:0]        w_addr_next;
    logic              w_en_next;
    logic [3:0]        ra_next;
    logic [3:0]        rb_next;
    logic [2:0]        alu_next;
    logic              halted_next;

    // Sequencing: next state, and PC/IR updates that only happen when leaving FETCH.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        case (state)
            S_INIT: begin
                pc_next    = '0;
                ir_next    = '0;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                ir_next    = I_Data;
                pc_next    = pc + 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                case (ir[15:12])
                    OP_STORE: state_next = S_STORE;
                    OP_LOAD:  state_next = S_LOAD_A;
                    OP_ADD:   state_next = S_ADD;
                    OP_SUB:   state_next = S_SUB;
                    OP_HALT:  state_next = S_HALT;
                    OP_NOOP:  state_next = S_NOOP;
                    default:  state_next = S_NOOP;
                endcase
            end
            S_LOAD_A: state_next = S_LOAD_B;
            S_HALT:   state_next = S_HALT;
            S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_next = S_FETCH;
            default:  state_next = S_INIT;
        endcase
    end

    // Control bus for the state about to be entered, so the registered outputs match it.
    always_comb begin
        d_addr_next = '0;
        d_wr_next   = 1'b0;
        rf_s_next   = 1'b0;
        w_addr_next = '0;
        w_en_next   = 1'b0;
        ra_next     = '0;
        rb_next     = '0;
        alu_next    = 3'b000;
        halted_next = 1'b0;
        case (state_next)
            S_LOAD_A, S_LOAD_B: begin
                d_addr_next = ir_next[11:4];
                rf_s_next   = 1'b1;
                w_addr_next = ir_next[3:0];
                w_en_next   = (state_next == S_LOAD_B);
            end
            S_STORE: begin
                d_addr_next = ir_next[11:4];
                ra_next     = ir_next[3:0];
                d_wr_next   = 1'b1;
            end
            S_ADD, S_SUB: begin
                ra_next     = ir_next[11:8];
                rb_next     = ir_next[7:4];
                w_addr_next = ir_next[3:0];
                w_en_next   = 1'b1;
                alu_next    = (state_next == S_ADD) ? 3'b001 : 3'b010;
            end
            S_HALT: halted_next = 1'b1;
            default: ;
        endcase
    end

    // State, PC, IR and registered control outputs; reset clears everything at once.
    always_ff @(posedge Clock or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_INIT;
            pc         <= '0;
            ir         <= '0;
            D_Addr     <= '0;
            D_Wr       <= 1'b0;
            RF_s       <= 1'b0;
            RF_W_Addr  <= '0;
            RF_W_en    <= 1'b0;
            RF_Ra_Addr <= '0;
            RF_Rb_Addr <= '0;
            ALU_s0     <= 3'b000;
            Halted     <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            ir         <= ir_next;
            D_Addr     <= d_addr_next;
            D_Wr       <= d_wr_next;
            RF_s       <= rf_s_next;
            RF_W_Addr  <= w_addr_next;
            RF_W_en    <= w_en_next;
            RF_Ra_Addr <= ra_next;
            RF_Rb_Addr <= rb_next;
            ALU_s0     <= alu_next;
            Halted     <= halted_next;
        end
    end

    assign I_Addr    = pc;
    assign PC_out    = pc;
    assign IR_out    = ir;
    assign State_out = state;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed, table-driven bench for control_unit with a
// synchronous instruction ROM model and hand-written multi-cycle sequences.
module tb_control_unit;

    logic        Clock;
    logic        n_rst;
    logic [6:0]  I_Addr;
    logic [15:0] I_Data;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic [3:0]  RF_W_Addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic [2:0]  ALU_s0;
    logic        Halted;
    logic [6:0]  PC_out;
    logic [15:0] IR_out;
    logic [3:0]  State_out;

    logic [15:0] rom [0:127];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rst;
        logic [3:0]  state;
        logic [6:0]  pc;
        logic [15:0] ir;
        logic [7:0]  d_addr;
        logic        d_wr;
        logic        rf_s;
        logic [3:0]  w_addr;
        logic        w_en;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
        logic        halted;
    } vec_t;

    vec_t vecs [21];

    control_unit #(.PC_W(7)) dut (
        .Clock      (Clock),
        .n_rst      (n_rst),
        .I_Addr     (I_Addr),
        .I_Data     (I_Data),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_Addr  (RF_W_Addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .ALU_s0     (ALU_s0),
        .Halted     (Halted),
        .PC_out     (PC_out),
        .IR_out     (IR_out),
        .State_out  (State_out)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Synchronous ROM: data appears one cycle after the address is presented.
    always @(posedge Clock) begin
        I_Data <= rom[I_Addr];
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    // Hold reset for two cycles, then release just after a falling edge.
    task automatic reset_dut();
        n_rst = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        n_rst = 1'b1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge Clock);
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        logic [26:0] ctl_act;
        logic [26:0] ctl_exp;
        n_rst = v.rst;
        @(negedge Clock);
        ctl_act = {D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0, Halted};
        ctl_exp = {v.d_addr, v.d_wr, v.rf_s, v.w_addr, v.w_en, v.ra, v.rb, v.alu, v.halted};
        check_output($sformatf("row%0d_state", idx), {28'd0, State_out}, {28'd0, v.state});
        check_output($sformatf("row%0d_pc", idx), {25'd0, PC_out}, {25'd0, v.pc});
        check_output($sformatf("row%0d_iaddr", idx), {25'd0, I_Addr}, {25'd0, v.pc});
        check_output($sformatf("row%0d_ir", idx), {16'd0, IR_out}, {16'd0, v.ir});
        check_output($sformatf("row%0d_ctl", idx), {5'd0, ctl_act}, {5'd0, ctl_exp});
    endtask

    initial begin
        n_rst = 1'b1;
        clear_rom();
        #1 n_rst = 1'b0;

        // Program: ADD, LOAD, STORE, SUB, unknown opcode, HALT.
        rom[0] = 16'h3123;
        rom[1] = 16'h2055;
        rom[2] = 16'h10A4;
        rom[3] = 16'h4561;
        rom[4] = 16'hF000;
        rom[5] = 16'h5000;

        //           rst  st     pc    ir        daddr  wr   s    wa    wen  ra    rb    alu     h
        vecs[0]  = '{1'b0, 4'd0, 7'd0, 16'h0000, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0};
        vecs[1]  = '{1'b1, 4'd1, 7'd0, 16'h0000, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0};
        vecs[2]  = '{1'b1, 4'd2, 7'd1, 16'h3123, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0};
        vecs[3]  = '{1'b1, 4'd7, 7'd1, 16'h3123, 8'h00, 1'b0, 1'b0, 4'd3, 1'b1, 4'd1, 4'd2, 3'b001, 1'b0};
        vecs[4]  = '{1'b1, 4'd1, 7'd1, 16'h3123, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0};
        vecs[5]  = '{1'b1, 4'd2, 7'd2, 16'h2055, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0};
        vecs[6]  = '{1'b1, 4'd4, 7'd2, 16'h2055, 8'h05, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0};
        vecs[7]  = '{1'b1, 4'd5, 7'd2, 16'h2055, 8'h05, 1'b0, 1'b1, 4'd5, 1'b1, 4'd0, 4'd0, 3'b000, 1'b0};
        vecs[8]  = '{1'b1, 4'd1, 7'd2, 16'h2055, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0};
        vecs[9]  = '{1'b1, 4'd2, 7'd3, 16'h10A4, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0};
        vecs[10] = '{1'b1, 4'd6, 7'd3, 16'h10A4, 8'h0A, 1'b1, 1'b0, 4'd0, 1'b0, 4'd4, 4'd0, 3'b000, 1'b0};
        vecs[11] = '{1'b1, 4'd1, 7'd3, 16'h10A4, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0};
        vecs[12] = '{1'b1, 4'd2, 7'd4, 16'h4561, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0};
        vecs[13] = '{1'b1, 4'd8, 7'd4, 16'h4561, 8'h00, 1'b0, 1'b0, 4'd1, 1'b1, 4'd5, 4'd6, 3'b010, 1'b0};
        vecs[14] = '{1'b1, 4'd1, 7'd4, 16'h4561, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0};
        vecs[15] = '{1'b1, 4'd2, 7'd5, 16'hF000, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0};
        vecs[16] = '{1'b1, 4'd3, 7'd5, 16'hF000, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0};
        vecs[17] = '{1'b1, 4'd1, 7'd5, 16'hF000, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0};
        vecs[18] = '{1'b1, 4'd2, 7'd6, 16'h5000, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0};
        vecs[19] = '{1'b1, 4'd9, 7'd6, 16'h5000, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b1};
        vecs[20] = '{1'b1, 4'd9, 7'd6, 16'h5000, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b1};

        @(negedge Clock);
        for (int i = 0; i < 21; i++) apply_stimulus(vecs[i], i);

        // Unknown opcode then HALT: NOOP path has no writes, PC freezes at 2.
        clear_rom();
        rom[0] = 16'hF000;
        rom[1] = 16'h5000;
        reset_dut();
        step(3);
        check_output("unk_state", {28'd0, State_out}, 32'd3);
        check_output("unk_writes", {30'd0, D_Wr, RF_W_en}, 32'd0);
        step(2);
        check_output("halt_ir", {16'd0, IR_out}, 32'h5000);
        step(1);
        check_output("halt_state", {28'd0, State_out}, 32'd9);
        for (int i = 0; i < 12; i++) begin
            step(1);
            check_output($sformatf("halt_hold%0d", i), {23'd0, Halted, D_Wr, RF_W_en, PC_out},
                         {23'd0, 1'b1, 1'b0, 1'b0, 7'd2});
        end

        // PC wrap: run NOOPs up to address 127, then ROM[0] holds HALT.
        begin
            bit found;
            found = 1'b0;
            clear_rom();
            reset_dut();
            for (int i = 0; i < 600 && !found; i++) begin
                step(1);
                if (PC_out == 7'd127) found = 1'b1;
            end
            check_output("wrap_reach127", {31'd0, found}, 32'd1);
            rom[0] = 16'h5000;
            if (found) begin
                step(3);
                check_output("wrap_pc0", {25'd0, PC_out}, 32'd0);
                check_output("wrap_state_dec", {28'd0, State_out}, 32'd2);
                step(3);
                check_output("wrap_ir_halt", {16'd0, IR_out}, 32'h5000);
                check_output("wrap_pc1", {25'd0, PC_out}, 32'd1);
                step(1);
                check_output("wrap_halted", {31'd0, Halted}, 32'd1);
            end
        end

        // Reset pulsed between edges while a STORE is writing.
        clear_rom();
        rom[0] = 16'h10A4;
        reset_dut();
        step(3);
        check_output("mid_store_wr", {31'd0, D_Wr}, 32'd1);
        check_output("mid_store_pc", {25'd0, PC_out}, 32'd1);
        #2 n_rst = 1'b0;
        #1;
        check_output("mid_rst_wr", {31'd0, D_Wr}, 32'd0);
        check_output("mid_rst_state", {28'd0, State_out}, 32'd0);
        check_output("mid_rst_pc", {25'd0, PC_out}, 32'd0);
        check_output("mid_rst_daddr", {24'd0, D_Addr}, 32'd0);
        @(negedge Clock);
        n_rst = 1'b1;
        step(2);
        check_output("post_rst_ir", {16'd0, IR_out}, 32'h10A4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-sequencing controller that sits directly upstream of the datapath: holds the program counter (PC) and instruction register (IR), and fetches 16-bit instructions from an external synchronous instruction ROM. A Moore FSM decodes each instruction into the datapath control bus: D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en, RF_Ra_Addr, RF_Rb_Addr and ALU_s0. It runs until a HALT instruction or reset.

## Interface
- PC_W, 7, PC and instruction-ROM address width; ROM depth is 2^PC_W words.
- Clock  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- I_Addr  out  PC_W  instruction-ROM address; equals PC at all times.
- I_Data  in  16  ROM read data; valid one cycle after I_Addr is stable (synchronous ROM).
- D_Addr  out  8  data-memory address.
- D_Wr  out  1  data-memory write enable.
- RF_s  out  1  register-file write mux select: 0 = ALU_out, 1 = data-memory output.
- RF_W_Addr  out  4  register-file write address.
- RF_W_en  out  1  register-file write enable.
- RF_Ra_Addr  out  4  register-file read port A address.
- RF_Rb_Addr  out  4  register-file read port B address.
- ALU_s0  out  3  ALU select: 3'b000 = idle, 3'b001 = A+B, 3'b010 = A−B.
- Halted  out  1  high while in HALT.
- PC_out  out  PC_W  debug copy of PC.
- IR_out  out  16  debug copy of IR.
- State_out  out  4  debug copy of the state encoding.

## Operation
- Instruction format: opcode = IR[15:12].
  - NOOP = 0000.
  - STORE = 0001: mem[IR[11:4]] ← RF[IR[3:0]].
  - LOAD = 0010: RF[IR[3:0]] ← mem[IR[11:4]].
  - ADD = 0011: RF[IR[3:0]] ← RF[IR[11:8]] + RF[IR[7:4]].
  - SUB = 0100: same fields as ADD, computes A−B.
  - HALT = 0101.
  - Opcodes 0110–1111 execute as NOOP.
- State encodings: INIT = 0, FETCH = 1, DECODE = 2, NOOP = 3, LOAD_A = 4, LOAD_B = 5, STORE = 6, ADD = 7, SUB = 8, HALT = 9.
- Default output values in every state: all control outputs 0 and Halted = 0, unless a state below sets them.
- INIT: PC = 0, IR = 0. Next state is FETCH.
- FETCH: on the exiting edge, IR ← I_Data and PC ← PC+1. PC wraps modulo 2^PC_W (127 → 0). Next state is DECODE.
- DECODE: no control outputs asserted. Next state is selected by opcode.
- NOOP: next state is FETCH.
- LOAD_A: D_Addr = IR[11:4], RF_s = 1, RF_W_Addr = IR[3:0], RF_W_en = 0. This cycle covers the data-memory read latency. Next state is LOAD_B.
- LOAD_B: same outputs as LOAD_A, except RF_W_en = 1. Next state is FETCH.
- STORE: D_Addr = IR[11:4], RF_Ra_Addr = IR[3:0], D_Wr = 1. Next state is FETCH.
- ADD and SUB:
  - RF_Ra_Addr = IR[11:8], RF_Rb_Addr = IR[7:4], RF_W_Addr = IR[3:0], RF_s = 0, RF_W_en = 1.
  - ALU_s0 = 001 for ADD, 010 for SUB.
  - Next state is FETCH.
- HALT: Halted = 1 and all write enables are 0. The FSM stays in HALT and PC is frozen. Only reset exits HALT.
- The IR loads only in FETCH. The PC changes only in FETCH and on reset.

## Timing
- Reset:
  - n_rst low immediately forces state INIT, PC = 0, IR = 0, with no clock required.
  - All outputs go to 0 combinationally: D_Wr, RF_W_en, Halted and the address buses.
  - Reset asserted during STORE or LOAD_B drops D_Wr or RF_W_en in the same cycle.
- After n_rst deasserts, the first rising edge moves INIT → FETCH.
- Outputs are Moore: a function of the registered state and IR only. They are stable for the whole state cycle; writes commit on the edge that leaves the state.
- Cycles per instruction, counted from FETCH entry: NOOP, STORE, ADD and SUB take 3; LOAD takes 4; HALT enters its state on the 3rd cycle.
- ROM timing: I_Addr = PC is stable for at least one full cycle before every FETCH edge. This holds in INIT and in the DECODE/execute cycles after each PC update.
- The datapath ALU result must be valid within the same cycle as the ADD/SUB state.

## Test plan
- Reset and first fetch: hold n_rst = 0 with ROM[0] = 16'h3123.
  - During reset, all outputs are 0 and State_out = 0.
  - After release, the 2nd edge gives IR_out = 16'h3123 and PC_out = 1.
  - The next cycle is ADD: Ra = 1, Rb = 2, W_Addr = 3, ALU_s0 = 001, RF_W_en = 1.
- LOAD 16'h2055: LOAD_A shows D_Addr = 8'h05, RF_s = 1, RF_W_en = 0. LOAD_B shows the same with RF_W_en = 1. FETCH follows.
- STORE 16'h10A4 then SUB 16'h4561:
  - STORE shows D_Addr = 8'h0A, RF_Ra_Addr = 4, D_Wr = 1 for exactly 1 cycle.
  - SUB shows Ra = 5, Rb = 6, W_Addr = 1, ALU_s0 = 010.
- Unknown opcode 16'hF000 followed by HALT 16'h5000:
  - The 0xF000 word traverses DECODE → NOOP with no writes.
  - Then Halted = 1 and PC_out stays at 2 for 10+ cycles.
- PC wrap: load ROM[127] = NOOP and ROM[0] = HALT. After fetching from 127, PC_out = 0 and the next instruction is HALT.
- Mid-instruction reset: pulse n_rst low between edges during STORE. D_Wr falls immediately, and State_out = 0 and PC_out = 0 without a clock edge.
